// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types and constants for the display BCD path
//
// Purpose: BCD digit type, converter FSM states, add-3 threshold and a helper
//          giving the minimum decimal digits needed for a binary width.
// Ports:   none (package)
package sseg_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bin2bcd_state_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

  // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103).
  function automatic int min_bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble per-digit add-3 correction
//
// Purpose: combinational correction applied to one BCD digit before each shift.
// Ports:   digit_in  - working BCD digit
//          digit_out - digit_in + 3 when digit_in >= 5, else digit_in
module bcd_add3
  import sseg_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Working digits never exceed 9 before correction, so +3 cannot wrap.
  assign digit_out = (digit_in >= BCD_ADD3_THRESH) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential one-bit-per-clock binary to packed BCD converter
//
// Purpose: double-dabble conversion with start/busy/done handshake for the
//          seven-segment display path.
// Ports:   clk        - system clock, rising edge
//          reset_n    - asynchronous active-low reset
//          bin_in     - unsigned binary value, sampled when start is accepted
//          start      - conversion request, level-sampled each clock
//          busy       - high while a conversion is in progress
//          done       - one-cycle pulse when bcd_out has been updated
//          bcd_out    - packed BCD result, digit 0 (units) in bits [3:0]
//          blank_mask - leading-zero blank flags (only with BIN2BCD_LZB_EN)
// Config:  BIN2BCD_LZB_EN enables the registered blank_mask output.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
`ifdef BIN2BCD_LZB_EN
  output logic [N_DIGITS-1:0]   blank_mask,
`endif
  output logic [4*N_DIGITS-1:0] bcd_out
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  if (N_DIGITS < min_bcd_digits(IN_W)) begin : g_digits_check
    $error("bin2bcd_seq: N_DIGITS too small for IN_W");
  end

  bin2bcd_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]      work_corr;
  logic [BCD_W+IN_W-1:0] shift_all;
  logic [BCD_W-1:0]      bcd_shift;
  logic [IN_W-1:0]       bin_shift;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (work_q[4*g +: 4]),
      .digit_out (work_corr[4*g +: 4])
    );
  end

  // The top bit of the corrected BCD field is always zero when N_DIGITS is
  // large enough, so dropping it in the shift loses nothing.
  assign shift_all = {work_corr, bin_q} << 1;
  assign bcd_shift = shift_all[BCD_W+IN_W-1 -: BCD_W];
  assign bin_shift = shift_all[IN_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    work_d    = work_q;
    bcd_out_d = bcd_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          work_d  = '0;
          cnt_d   = CNT_W'(IN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d  = bin_shift;
        work_d = bcd_shift;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d = bcd_shift;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      work_q    <= '0;
      bcd_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      bcd_out_q <= bcd_out_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_out_q;

`ifdef BIN2BCD_LZB_EN
  logic [N_DIGITS-1:0] blank_mask_q, blank_mask_d;
  logic [N_DIGITS-1:0] blank_calc;
  logic                zero_above;

  // Bit i is set when digit i and every higher digit are zero; the units
  // digit is never blanked so a value of 0 still shows "0".
  always_comb begin
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (bcd_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_above;
    end
  end

  always_comb begin
    blank_mask_d = blank_mask_q;
    if (state_q == SHIFT && cnt_q == CNT_W'(1)) begin
      blank_mask_d = blank_calc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_mask_q <= '0;
    end else begin
      blank_mask_q <= blank_mask_d;
    end
  end

  assign blank_mask = blank_mask_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset_n;
  logic [15:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
`ifdef BIN2BCD_LZB_EN
  logic [4:0]  blank_mask;
`endif

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.IN_W(16), .N_DIGITS(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bin_in     (bin_in),
    .start      (start),
    .busy       (busy),
    .done       (done),
`ifdef BIN2BCD_LZB_EN
    .blank_mask (blank_mask),
`endif
    .bcd_out    (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=00000", bcd_out); end
`ifdef BIN2BCD_LZB_EN
    checks++; if (blank_mask !== 5'b0) begin errors++; $display("FAIL reset_mask got=%b exp=00000", blank_mask); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_zero();
    int busy_bad  = 0;
    int early_done = 0;
    @(negedge clk);
    bin_in = 16'd0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start got=%b exp=1", busy); end
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin
        if (busy !== 1'b1) busy_bad++;
        if (done !== 1'b0) early_done++;
      end
      @(posedge clk); #1;
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL zero_busy_hold got=%0d low cycles exp=0", busy_bad); end
    checks++; if (early_done != 0) begin errors++; $display("FAIL zero_early_done got=%0d exp=0", early_done); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_latency done got=%b exp=1 at cycle 16", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end got=%b exp=0", busy); end
    checks++; if (bcd_out !== 20'h00000) begin errors++; $display("FAIL zero_bcd got=%h exp=00000", bcd_out); end
`ifdef BIN2BCD_LZB_EN
    checks++; if (blank_mask !== 5'b11110) begin errors++; $display("FAIL zero_mask got=%b exp=11110", blank_mask); end
`endif
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_values();
    logic [15:0] vals  [5] = '{16'd65535, 16'd1234, 16'd42, 16'd100, 16'd9999};
    logic [19:0] exps  [5] = '{20'h65535, 20'h01234, 20'h00042, 20'h00100, 20'h09999};
    logic [4:0]  masks [5] = '{5'b00000, 5'b10000, 5'b11100, 5'b11000, 5'b10000};
    logic [19:0] prev = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bin_in = vals[i];
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        @(posedge clk); #1;
        if (c == 8) begin
          checks++;
          if (bcd_out !== prev) begin errors++; $display("FAIL value_hold[%0d] got=%h exp=%h", i, bcd_out, prev); end
        end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL value_done[%0d] got=%b exp=1", i, done); end
      checks++; if (bcd_out !== exps[i]) begin errors++; $display("FAIL value_bcd[%0d] got=%h exp=%h", i, bcd_out, exps[i]); end
`ifdef BIN2BCD_LZB_EN
      checks++; if (blank_mask !== masks[i]) begin errors++; $display("FAIL value_mask[%0d] got=%b exp=%b", i, blank_mask, masks[i]); end
`else
      if (masks[i] == 5'b11111) $display("unexpected mask entry");
`endif
      prev = exps[i];
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int done_cycle = -1;
    @(negedge clk);
    bin_in = 16'd1234;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        bin_in = 16'd999;
        start  = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (done_cycle < 0) begin
          done_cycle = c;
          checks++;
          if (bcd_out !== 20'h01234) begin errors++; $display("FAIL ignore_bcd got=%h exp=01234", bcd_out); end
        end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (done_cycle != 16) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=16", done_cycle); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exps [4] = '{20'h00007, 20'h00300, 20'h00007, 20'h00300};
    int idx = 0;
    int last = -1;
    @(negedge clk);
    bin_in = 16'd7;
    start  = 1'b1;
    for (int c = 1; c <= 120 && idx < 4; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        checks++;
        if (bcd_out !== exps[idx]) begin errors++; $display("FAIL b2b_bcd[%0d] got=%h exp=%h", idx, bcd_out, exps[idx]); end
        if (last >= 0) begin
          checks++;
          if (c - last != 17) begin errors++; $display("FAIL b2b_period[%0d] got=%0d exp=17", idx, c - last); end
        end
        last = c;
        bin_in = (idx % 2 == 0) ? 16'd300 : 16'd7;
        idx++;
        if (idx == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", idx); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b done=%b exp=0,0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    bin_in = 16'd65535;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (bcd_out !== 20'h00300) begin errors++; $display("FAIL rmid_hold got=%h exp=00300", bcd_out); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", done); end
    checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL rmid_bcd got=%h exp=00000", bcd_out); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
    @(negedge clk);
    bin_in = 16'd65535;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_after_done got=%b exp=1", done); end
    checks++; if (bcd_out !== 20'h65535) begin errors++; $display("FAIL rmid_after_bcd got=%h exp=65535", bcd_out); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
